// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder for a MIPS core: lw/sw always, lb/lbu/sb only
// when DMEM_RESPONDER_BYTE_EN is defined (otherwise they report err).
module dmem_responder #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [5:0]  opcode,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
  localparam logic [5:0]  OP_LW    = 6'h23;
  localparam logic [5:0]  OP_SW    = 6'h2B;
`ifdef DMEM_RESPONDER_BYTE_EN
  localparam logic [5:0]  OP_LB    = 6'h20;
  localparam logic [5:0]  OP_LBU   = 6'h24;
  localparam logic [5:0]  OP_SB    = 6'h28;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_mw;
  logic [5:0]    r_op;
  logic [31:0]   r_adr;
  logic [31:0]   r_wd;
  logic [31:0]   r_mem [DEPTH];

  logic          w_idle;
  logic          w_enter_resp;
  logic          w_src_mw;
  logic [5:0]    w_src_op;
  logic [31:0]   w_src_adr;
  logic [31:0]   w_src_wd;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_word;
  logic [31:0]   w_rdata;
  logic          w_err;
  logic          w_we_word;
  logic          w_unused_adr;
`ifdef DMEM_RESPONDER_BYTE_EN
  logic [7:0]    w_byte;
  logic          w_we_byte;
`endif

  // With WAIT=0 the access happens on the accepting edge, so use the live inputs
  assign w_idle       = (r_state == S_IDLE);
  assign w_src_mw     = w_idle ? memwrite  : r_mw;
  assign w_src_op     = w_idle ? opcode    : r_op;
  assign w_src_adr    = w_idle ? dataadr   : r_adr;
  assign w_src_wd     = w_idle ? writedata : r_wd;
  assign w_enter_resp = (w_idle && req && (WAIT == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));

  assign w_idx        = w_src_adr[AW+1:2];
  assign w_lane       = w_src_adr[1:0];
  assign w_word       = r_mem[w_idx];
  assign w_unused_adr = ^w_src_adr[31:AW+2];
`ifdef DMEM_RESPONDER_BYTE_EN
  assign w_byte       = w_word[{w_lane, 3'b000} +: 8];
`endif

  // Access decode: anything not explicitly legal reports err with no side effect
  always_comb begin
    w_rdata   = 32'd0;
    w_err     = 1'b1;
    w_we_word = 1'b0;
`ifdef DMEM_RESPONDER_BYTE_EN
    w_we_byte = 1'b0;
`endif
    case (w_src_op)
      OP_LW: if (!w_src_mw && (w_lane == 2'd0)) begin
        w_rdata = w_word;
        w_err   = 1'b0;
      end
      OP_SW: if (w_src_mw && (w_lane == 2'd0)) begin
        w_we_word = 1'b1;
        w_err     = 1'b0;
      end
`ifdef DMEM_RESPONDER_BYTE_EN
      OP_LB: if (!w_src_mw) begin
        w_rdata = {{24{w_byte[7]}}, w_byte};
        w_err   = 1'b0;
      end
      OP_LBU: if (!w_src_mw) begin
        w_rdata = {24'd0, w_byte};
        w_err   = 1'b0;
      end
      OP_SB: if (w_src_mw) begin
        w_we_byte = 1'b1;
        w_err     = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  // Control FSM; memory writes live here so a reset in flight can never commit a store
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_mw     <= 1'b0;
      r_op     <= 6'd0;
      r_adr    <= 32'd0;
      r_wd     <= 32'd0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      readdata <= 32'd0;
    end else begin
      ready <= 1'b0;
      case (r_state)
        S_IDLE: if (req) begin
          r_mw  <= memwrite;
          r_op  <= opcode;
          r_adr <= dataadr;
          r_wd  <= writedata;
          busy  <= 1'b1;
          if (WAIT == 0) begin
            r_state <= S_RESP;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
      if (w_enter_resp) begin
        ready    <= 1'b1;
        readdata <= w_rdata;
        err      <= w_err;
        if (w_we_word) r_mem[w_idx] <= w_src_wd;
`ifdef DMEM_RESPONDER_BYTE_EN
        if (w_we_byte) r_mem[w_idx][{w_lane, 3'b000} +: 8] <= w_src_wd[7:0];
`endif
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning number of 32-bit memory words (power of two, 4..1024).
REQ-002 The block SHALL have parameter WAIT, default 2, meaning wait-state cycles before response (0..15).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req  input  1  access request from the processor, sampled only in IDLE.
REQ-006 The block SHALL have port memwrite  input  1  1 = store, 0 = load; qualified by req.
REQ-007 The block SHALL have port opcode  input  6  MIPS opcode selecting access size: lw 0x23, lb 0x20, lbu 0x24, sw 0x2B, sb 0x28.
REQ-008 The block SHALL have port dataadr  input  32  byte address of the access.
REQ-009 The block SHALL have port writedata  input  32  store data; sb uses bits 7:0.
REQ-010 The block SHALL have port readdata  output  32  registered load result.
REQ-011 The block SHALL have port ready  output  1  one-cycle response strobe.
REQ-012 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 The block SHALL have port err  output  1  registered error flag, valid while ready is high.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-015 In IDLE with req=1 at an edge, the block SHALL capture memwrite, opcode, dataadr and writedata, then go to WAIT (counter = WAIT-1) if WAIT>0, else to RESP.
REQ-016 In WAIT, the counter SHALL decrement each edge; at an edge with counter=0 the state SHALL go to RESP.
REQ-017 Transitions out of RESP SHALL always go to IDLE after exactly one cycle; ready = (state==RESP).
REQ-018 ready SHALL therefore rise WAIT+1 edges after the accepting edge and stay high for exactly one cycle.
REQ-019 req SHALL be ignored in WAIT and RESP; a request held through RESP is accepted at the first edge in IDLE.
REQ-020 The memory access SHALL be performed at the edge entering RESP: store commits, readdata and err are registered from pre-store contents.
REQ-021 The word index SHALL be dataadr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-022 Byte lanes SHALL be little-endian: dataadr[1:0]=0 selects bits 7:0, 3 selects bits 31:24.
REQ-023 lb SHALL sign-extend the selected byte; lbu SHALL zero-extend it; sb SHALL modify only the selected byte.
REQ-024 lw/sw with dataadr[1:0]!=0 SHALL set err=1, perform no write, and return readdata=0.
REQ-025 Any opcode other than REQ-007 values, or an opcode inconsistent with memwrite, SHALL set err=1, no write, readdata=0.
REQ-026 On successful access err SHALL be 0; readdata for stores SHALL be 0; readdata and err SHALL hold until the next RESP entry.

Reset
REQ-027 reset low SHALL immediately force state=IDLE, counter=0, ready=0, busy=0, err=0, readdata=0, captured request registers=0.
REQ-028 Reset asserted mid-access SHALL abort it; a store not yet at its RESP-entry edge SHALL NOT modify memory.
REQ-029 Memory array contents SHALL NOT be reset.

Configuration
REQ-030 With macro DMEM_RESPONDER_BYTE_EN defined, lb, lbu and sb SHALL be supported per REQ-022/023.
REQ-031 Without DMEM_RESPONDER_BYTE_EN, lb, lbu and sb SHALL be treated as unsupported opcodes per REQ-025; word accesses unchanged.

Verification
REQ-032 WAIT=2: sw 0x2B, adr 0x10, data 0xDEADBEEF, then lw adr 0x10 -> each ready exactly 3 edges after acceptance; readdata=0xDEADBEEF, err=0.
REQ-033 BYTE_EN defined: after REQ-032, sb adr 0x11 data 0x00000080, then lb adr 0x11 -> 0xFFFFFF80; lbu adr 0x11 -> 0x00000080; lw adr 0x10 -> 0xDEAD80EF.
REQ-034 lw adr 0x12 -> ready with err=1, readdata=0; sw adr 0x13 data 0x12345678 -> err=1, subsequent lw 0x10 unchanged.
REQ-035 DEPTH=64: sw adr 0x100 data 0xA5A5A5A5, then lw adr 0x000 -> 0xA5A5A5A5 (wrap).
REQ-036 sw adr 0x20 data 0x11111111; reset pulsed low 1 cycle after acceptance -> ready never asserts, busy=0 immediately, later lw 0x20 returns prior contents.
REQ-037 WAIT=0, req held high continuously -> ready pulses every 2 cycles, busy high in RESP only; BYTE_EN undefined: lb adr 0x10 -> err=1, readdata=0.
